// File: rtl/or_arb_pkg.sv
// Shared types and defaults for the two-requester OR arbiter.
package or_arb_pkg;

  localparam int unsigned OR_ARB_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with the last_grant register; grants only when en_i is high.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o,
  output logic       gnt_id_o
);

  logic last_q;
  logic last_d;
  logic id_c;

  always_comb begin
    // Contention goes to the requester that did not win last time.
    if (req_i == 2'b11) id_c = ~last_q;
    else                id_c = req_i[1];
    gnt_o  = '0;
    last_d = last_q;
    if (en_i && (|req_i)) begin
      gnt_o[id_c] = 1'b1;
      last_d      = id_c;
    end
  end

  assign gnt_id_o = id_c;

  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/or_arbiter.sv
// Arbitrates two requesters and returns the bitwise OR of the granted operands.
module or_arbiter
  import or_arb_pkg::*;
#(
  parameter int unsigned W = OR_ARB_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_f,
  output logic         busy
);

  state_e       state_q;
  state_e       state_d;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic         id_q;
  logic [W-1:0] rsp_f_q;
  logic         rsp_id_q;
  logic [1:0]   gnt;
  logic         gnt_id;
  logic         arb_en;

  assign arb_en = (state_q == ST_IDLE) && !rst;

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req_valid),
    .en_i     (arb_en),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (|gnt)     state_d = ST_EXEC;
      ST_EXEC:               state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= 1'b0;
      rsp_f_q  <= '0;
      rsp_id_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (|gnt) begin
        a_q  <= gnt_id ? a1 : a0;
        b_q  <= gnt_id ? b1 : b0;
        id_q <= gnt_id;
      end
      if (state_q == ST_EXEC) begin
        rsp_f_q  <= a_q | b_q;
        rsp_id_q <= id_q;
      end
    end
  end

  assign req_ready = gnt;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_f     = rsp_f_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_or_arbiter.sv
// Directed bench for or_arbiter: inputs driven 1ns after posedge, outputs checked on negedge.
module tb_or_arbiter;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [W-1:0] a0, b0, a1, b1;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [W-1:0] rsp_f;
  logic         busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  or_arbiter #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .a0        (a0),
    .b0        (b0),
    .a1        (a1),
    .b1        (b1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_f     (rsp_f),
    .busy      (busy)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 2'b00;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    a0 = 8'h5A; b0 = 8'hA5; a1 = 8'h33; b1 = 8'hCC;
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready cyc%0d: got %b want 00", i, req_ready); end
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid cyc%0d: got %b want 0", i, rsp_valid); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy cyc%0d: got %b want 0", i, busy); end
      checks++;
      if (rsp_f !== 8'h00 || rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp: got f=%h id=%b want 00/0", rsp_f, rsp_id); end
      next_cycle();
    end
    rst = 1'b0;
    req_valid = 2'b00;
  endtask

  task automatic test_single();
    a0 = 8'h0F; b0 = 8'hF0; req_valid = 2'b01; rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL single_grant: got %b want 01", req_ready); end
    next_cycle();
    req_valid = 2'b00;
    a0 = 8'h00; b0 = 8'h00;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || rsp_valid !== 1'b0 || req_ready !== 2'b00)
      begin errors++; $display("FAIL single_exec: got busy=%b valid=%b rdy=%b want 1/0/00", busy, rsp_valid, req_ready); end
    next_cycle();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_f !== 8'hFF || rsp_id !== 1'b0)
      begin errors++; $display("FAIL single_resp: got v=%b f=%h id=%b want 1/ff/0", rsp_valid, rsp_f, rsp_id); end
    next_cycle();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL single_idle: got v=%b busy=%b want 0/0", rsp_valid, busy); end
    next_cycle();
  endtask

  task automatic test_contention();
    logic         exp_id;
    logic [W-1:0] exp_f;
    a0 = 8'h01; b0 = 8'h02; a1 = 8'h10; b1 = 8'h20;
    req_valid = 2'b11; rsp_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      exp_id = t[0];
      exp_f  = exp_id ? 8'h30 : 8'h03;
      @(negedge clk);
      checks++;
      if (req_ready !== (exp_id ? 2'b10 : 2'b01))
        begin errors++; $display("FAIL contention_grant%0d: got %b want id %0d", t, req_ready, exp_id); end
      next_cycle();
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b00) begin errors++; $display("FAIL contention_exec_rdy%0d: got %b want 00", t, req_ready); end
      next_cycle();
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_f !== exp_f || rsp_id !== exp_id || req_ready !== 2'b00)
        begin errors++; $display("FAIL contention_resp%0d: got v=%b f=%h id=%b rdy=%b want 1/%h/%b/00",
                                 t, rsp_valid, rsp_f, rsp_id, req_ready, exp_f, exp_id); end
      next_cycle();
    end
    req_valid = 2'b00;
  endtask

  task automatic test_backpressure();
    a0 = 8'hAA; b0 = 8'h05; req_valid = 2'b01; rsp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_grant: got %b want 01", req_ready); end
    next_cycle();
    req_valid = 2'b00;
    next_cycle();
    req_valid = 2'b01;
    for (int k = 0; k < 5; k++) begin
      a0 = 8'h40 + 8'(k);
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_f !== 8'hAF || rsp_id !== 1'b0 || req_ready !== 2'b00)
        begin errors++; $display("FAIL bp_hold%0d: got v=%b f=%h id=%b rdy=%b want 1/af/0/00",
                                 k, rsp_valid, rsp_f, rsp_id, req_ready); end
      next_cycle();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || req_ready !== 2'b00)
      begin errors++; $display("FAIL bp_complete: got v=%b rdy=%b want 1/00", rsp_valid, req_ready); end
    next_cycle();
    req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL bp_idle: got v=%b busy=%b want 0/0", rsp_valid, busy); end
    next_cycle();
  endtask

  task automatic test_operand_change();
    a1 = 8'h00; b1 = 8'h3C; req_valid = 2'b10; rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b10) begin errors++; $display("FAIL opchg_grant: got %b want 10", req_ready); end
    next_cycle();
    a1 = 8'hFF; req_valid = 2'b00;
    next_cycle();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_f !== 8'h3C || rsp_id !== 1'b1)
      begin errors++; $display("FAIL opchg_resp: got v=%b f=%h id=%b want 1/3c/1", rsp_valid, rsp_f, rsp_id); end
    next_cycle();
  endtask

  task automatic test_midop_reset();
    a0 = 8'h11; b0 = 8'h22; a1 = 8'h44; b1 = 8'h88;
    req_valid = 2'b01; rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL midrst_grant: got %b want 01", req_ready); end
    next_cycle();
    req_valid = 2'b11;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b00) begin errors++; $display("FAIL midrst_rdy_in_rst: got %b want 00", req_ready); end
    next_cycle();
    rst = 1'b0;
    req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL midrst_abort: got v=%b busy=%b want 0/0", rsp_valid, busy); end
    next_cycle();
    req_valid = 2'b11;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL midrst_first_grant: got %b want 01", req_ready); end
    next_cycle();
    req_valid = 2'b00;
    next_cycle();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_f !== 8'h33 || rsp_id !== 1'b0)
      begin errors++; $display("FAIL midrst_resp: got v=%b f=%h id=%b want 1/33/0", rsp_valid, rsp_f, rsp_id); end
    next_cycle();
  endtask

  initial begin
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    test_reset();
    test_single();
    do_reset();
    test_contention();
    test_backpressure();
    test_operand_change();
    test_midop_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, limit 100000 ns");
    $fatal(1);
  end

endmodule
